// File: rtl/gpu_rect_fill.sv
// Rectangle-fill engine: clips a latched rectangle to the framebuffer and streams
// one VRAM write per pixel, honouring vram_ready_i backpressure and abort_i.
module gpu_rect_fill #(
  parameter int FB_W    = 80,
  parameter int FB_H    = 60,
  parameter int COORD_W = 8,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 12
) (
  input  logic               clk,
  input  logic               RST_N,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [COORD_W-1:0] x0_i,
  input  logic [COORD_W-1:0] y0_i,
  input  logic [COORD_W-1:0] w_i,
  input  logic [COORD_W-1:0] h_i,
  input  logic [DATA_W-1:0]  color_i,
  input  logic               vram_ready_i,
  output logic               vram_we_o,
  output logic [ADDR_W-1:0]  vram_addr_o,
  output logic [DATA_W-1:0]  vram_data_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  state_t              state, state_nxt;
  logic [COORD_W-1:0]  x0_q, y0_q, w_q, h_q;
  logic [COORD_W-1:0]  cw_q, ch_q, col_q, row_q;
  logic [DATA_W-1:0]   color_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [COORD_W-1:0]  cw_s, ch_s;
  logic [ADDR_W-1:0]   base_s;
  logic                xfer, last_col, last_row;

  // Visible run length along one axis: zero when the origin is off-screen,
  // otherwise the requested length saturated at the framebuffer edge.
  function automatic logic [COORD_W-1:0] clip_len(input logic [COORD_W-1:0] org,
                                                  input logic [COORD_W-1:0] len,
                                                  input logic [31:0]        lim);
    logic [31:0] room;
    if (32'(org) >= lim) return '0;
    room = lim - 32'(org);
    if (32'(len) < room) return len;
    return COORD_W'(room);
  endfunction

  assign cw_s     = clip_len(x0_q, w_q, 32'(FB_W));
  assign ch_s     = clip_len(y0_q, h_q, 32'(FB_H));
  assign base_s   = ADDR_W'(32'(y0_q) * 32'(FB_W) + 32'(x0_q));
  assign xfer     = (state == FILL) && vram_ready_i;
  assign last_col = (col_q == cw_q - COORD_W'(1));
  assign last_row = (row_q == ch_q - COORD_W'(1));

  assign vram_addr_o = addr_q;
  assign vram_data_o = color_q;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    vram_we_o = 1'b0;
    done_o    = 1'b0;
    busy_o    = 1'b1;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_nxt = SETUP;
      end
      SETUP: begin
        if (abort_i || cw_s == '0 || ch_s == '0) state_nxt = DONE;
        else                                     state_nxt = FILL;
      end
      FILL: begin
        vram_we_o = 1'b1;
        if (abort_i || (xfer && last_col && last_row)) state_nxt = DONE;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      cw_q    <= '0;
      ch_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
    end else begin
      if (state == IDLE && start_i) begin
        x0_q    <= x0_i;
        y0_q    <= y0_i;
        w_q     <= w_i;
        h_q     <= h_i;
        color_q <= color_i;
      end
      if (state == SETUP) begin
        cw_q   <= cw_s;
        ch_q   <= ch_s;
        col_q  <= '0;
        row_q  <= '0;
        addr_q <= base_s;
      end
      // Row wrap rewinds to the rectangle's left edge on the next scanline.
      if (xfer) begin
        if (!last_col) begin
          col_q  <= col_q + COORD_W'(1);
          addr_q <= addr_q + ADDR_W'(1);
        end else if (!last_row) begin
          col_q  <= '0;
          row_q  <= row_q + COORD_W'(1);
          addr_q <= addr_q + ADDR_W'(FB_W) - ADDR_W'(cw_q) + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/gpu_rect_fill.md
Name: gpu_rect_fill

Overview:
- Hardware rectangle-fill engine directly upstream of the GPU VRAM write port.
- The CPU-side IO register logic latches the rectangle coordinates and colour, then pulses start.
- The block emits one VRAM write per pixel (address, 12-bit colour, write enable) into the GPU, clipped to the framebuffer.
- It offloads per-pixel IOBUS stores; the done pulse may be ORed into the MCU interrupt line.

Parameters:
- FB_W, 80, framebuffer width in pixels; VRAM address = y*FB_W + x
- FB_H, 60, framebuffer height in pixels
- COORD_W, 8, width of the x0/y0/w/h fields
- ADDR_W, 16, VRAM address width
- DATA_W, 12, pixel colour width (4:4:4 RGB)

Ports:
- clk  in  1  system clock (50 MHz domain)
- RST_N  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle request; sampled only in IDLE
- abort_i  in  1  terminate current fill; takes effect next edge
- x0_i  in  COORD_W  left column
- y0_i  in  COORD_W  top row
- w_i  in  COORD_W  width in pixels
- h_i  in  COORD_W  height in pixels
- color_i  in  DATA_W  fill colour
- vram_ready_i  in  1  GPU accepts the write this cycle
- vram_we_o  out  1  write request (valid)
- vram_addr_o  out  ADDR_W  pixel address
- vram_data_o  out  DATA_W  pixel colour
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle completion pulse, also on abort

Behaviour:
- Interface: one clock `clk`; reset `RST_N` is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, all internal registers 0. Reset asserted mid-fill stops writes immediately; no done pulse.
- States: IDLE -> SETUP -> FILL -> DONE -> IDLE.
- IDLE:
  - If start_i=1 at a clock edge, latch x0, y0, w, h, colour and go to SETUP.
  - start_i in any other state is ignored; no queueing.
- SETUP, exactly 1 cycle:
  - cw = 0 if x0>=FB_W, else min(w, FB_W-x0). ch is computed likewise from y0, h, FB_H.
  - base = y0*FB_W + x0, truncated to ADDR_W.
  - If cw=0 or ch=0, go to DONE (no writes). Otherwise go to FILL with col=0, row=0, addr=base.
- FILL:
  - vram_we_o=1, vram_addr_o=addr, vram_data_o=latched colour.
  - A write is transferred only on a cycle where vram_we_o=1 and vram_ready_i=1.
  - While vram_ready_i=0, hold addr/data/we stable: no skip, no duplicate.
  - On transfer, if col<cw-1: col++, addr++.
  - On transfer, else if row<ch-1: col=0, row++, addr = addr - (cw-1) + FB_W.
  - On transfer, else (last pixel): go to DONE.
- DONE, 1 cycle: vram_we_o=0, done_o=1, then IDLE.
- abort_i=1 in SETUP or FILL: go to DONE next edge. A write transferred on that same edge counts; no further writes follow. abort_i in IDLE/DONE has no effect.
- Latency with vram_ready_i held 1 and start sampled at edge k:
  - SETUP during cycle k+1.
  - Writes during cycles k+2 .. k+1+cw*ch.
  - done_o in the following cycle.
- Coordinates are unsigned; no wrap-around. Clipping guarantees every address is < FB_W*FB_H.
- vram_we_o is combinationally a function of state only, never of vram_ready_i.

Test Plan:
- Reset: hold RST_N=0, then release with start_i=0 -> all outputs 0, busy_o=0, no vram_we_o for 20 cycles.
- Basic fill: x0=2, y0=3, w=3, h=2, color=0xF00, ready=1, start at edge k.
  - Writes at addresses 242, 243, 244, 322, 323, 324, data 0xF00, in cycles k+2..k+7.
  - done_o=1 in cycle k+8; busy_o falls at edge k+9.
- Clipping: x0=78, y0=59, w=5, h=4 -> exactly 2 writes (4798, 4799), then done_o. Separately x0=80 -> zero writes, done_o at k+2.
- Backpressure: basic fill with vram_ready_i=0 for 3 cycles while the 2nd write (243) is presented.
  - 243 is held stable for 4 cycles; total of 6 unique writes, none duplicated.
  - done_o is delayed by 3 cycles (k+11).
- Abort/ignore: pulse start_i again during FILL -> ignored. Assert abort_i on the cycle presenting address 323 with ready=1 -> 323 written, no 324, done_o next cycle.
- Reset mid-fill: drop RST_N during the 3rd write -> vram_we_o=0 immediately, no done_o; a new fill after release behaves as in the basic fill scenario.
